// File: rtl/rt_ibex_pcs_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rt_ibex_pcs_stack: context save/restore stack for nested interrupts.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rt_ibex_pcs_stack #(
    parameter int unsigned NrSavedRegs = 9,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned Depth       = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   push_i,
    input  logic [NrSavedRegs-1:0][DataWidth-1:0]  store_data_i,
    input  logic                                   pop_i,
    input  logic                                   err_clr_i,
    output logic [NrSavedRegs-1:0][DataWidth-1:0]  restore_data_o,
    output logic                                   restore_valid_o,
    output logic                                   busy_o,
    output logic [$clog2(Depth+1)-1:0]             depth_o,
    output logic                                   full_o,
    output logic                                   empty_o,
    output logic                                   overflow_o,
    output logic                                   underflow_o
);

    localparam int unsigned SpW  = $clog2(Depth + 1);
    localparam int unsigned IdxW = $clog2(Depth);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StRead  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    typedef logic [NrSavedRegs-1:0][DataWidth-1:0] ctx_t;

    logic [1:0]     state_q, state_d;
    logic [SpW-1:0] sp_q, sp_d;
    ctx_t           stg_q, stg_d;
    ctx_t           pend_data_q, pend_data_d;
    logic           pend_v_q, pend_v_d;
    ctx_t           rdata_q;
    ctx_t           mem_q [Depth];
    logic           ovf_q, unf_q;
    logic           ovf_set, unf_set;
    logic           full, empty;
    logic [IdxW-1:0] idx;

    assign full  = (sp_q == SpW'(Depth));
    assign empty = (sp_q == '0);
    assign idx   = sp_q[IdxW-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (pend_v_q) begin
                    if (!full) state_d = StWrite;
                end else if (push_i) begin
                    if (!full) state_d = StWrite;
                end else if (pop_i && !empty) begin
                    state_d = StRead;
                end
            end
            StWrite: state_d = StIdle;
            StRead:  state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o          = (state_q != StIdle);
        restore_valid_o = (state_q == StResp);
    end

    // Datapath control; a push arriving while busy lands in the pending slot.
    always_comb begin
        sp_d        = sp_q;
        stg_d       = stg_q;
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        case (state_q)
            StIdle: begin
                if (pend_v_q) begin
                    pend_v_d = 1'b0;
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        stg_d = pend_data_q;
                    end
                    if (push_i) begin
                        pend_v_d    = 1'b1;
                        pend_data_d = store_data_i;
                    end
                end else if (push_i) begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        stg_d = store_data_i;
                    end
                end else if (pop_i) begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        sp_d = sp_q - SpW'(1);
                    end
                end
            end
            StWrite: sp_d = sp_q + SpW'(1);
            default: ;
        endcase
        if ((state_q != StIdle) && push_i) begin
            if (!pend_v_q) begin
                pend_v_d    = 1'b1;
                pend_data_d = store_data_i;
            end else begin
                ovf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sp_q     <= '0;
            pend_v_q <= 1'b0;
        end else begin
            sp_q     <= sp_d;
            pend_v_q <= pend_v_d;
        end
    end

    always_ff @(posedge clk_i) begin
        stg_q       <= stg_d;
        pend_data_q <= pend_data_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && (state_q == StWrite)) begin
            mem_q[idx] <= stg_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (state_q == StRead) begin
            rdata_q <= mem_q[idx];
        end
    end

    // Clear wins over a same-cycle set.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (err_clr_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set) ovf_q <= 1'b1;
            if (unf_set) unf_q <= 1'b1;
        end
    end

    assign restore_data_o = rdata_q;
    assign depth_o        = sp_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_rt_ibex_pcs_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rt_ibex_pcs_stack: directed self-checking bench, Depth=4.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rt_ibex_pcs_stack;

    localparam int NR = 9;
    localparam int DW = 32;
    localparam int W  = NR * DW;

    logic                   clk_i;
    logic                   rst_ni;
    logic                   push_i;
    logic [NR-1:0][DW-1:0]  store_data_i;
    logic                   pop_i;
    logic                   err_clr_i;
    logic [NR-1:0][DW-1:0]  restore_data_o;
    logic                   restore_valid_o;
    logic                   busy_o;
    logic [2:0]             depth_o;
    logic                   full_o;
    logic                   empty_o;
    logic                   overflow_o;
    logic                   underflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    rt_ibex_pcs_stack #(
        .NrSavedRegs (NR),
        .DataWidth   (DW),
        .Depth       (4)
    ) u_dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .push_i          (push_i),
        .store_data_i    (store_data_i),
        .pop_i           (pop_i),
        .err_clr_i       (err_clr_i),
        .restore_data_o  (restore_data_o),
        .restore_valid_o (restore_valid_o),
        .busy_o          (busy_o),
        .depth_o         (depth_o),
        .full_o          (full_o),
        .empty_o         (empty_o),
        .overflow_o      (overflow_o),
        .underflow_o     (underflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [W-1:0] pat(input logic [7:0] b);
        return {(W/8){b}};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_push(input logic [W-1:0] d);
        push_i       = 1'b1;
        store_data_i = d;
        tick();
        push_i = 1'b0;
        tick();
    endtask

    task automatic do_pop(output logic [W-1:0] d);
        bit seen;
        seen  = 1'b0;
        d     = '0;
        pop_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (restore_valid_o) begin
                d    = restore_data_o;
                seen = 1'b1;
                break;
            end
        end
        pop_i = 1'b0;
        check("pop_valid_seen", W'(seen), W'(1));
        tick();
    endtask

    logic [W-1:0] rd;

    initial begin
        rst_ni       = 1'b0;
        push_i       = 1'b0;
        pop_i        = 1'b0;
        err_clr_i    = 1'b0;
        store_data_i = '0;
        tick();
        tick();
        rst_ni = 1'b1;

        check("rst_depth", W'(depth_o), W'(0));
        check("rst_empty", W'(empty_o), W'(1));
        check("rst_full",  W'(full_o),  W'(0));
        check("rst_busy",  W'(busy_o),  W'(0));
        check("rst_valid", W'(restore_valid_o), W'(0));
        check("rst_ovf",   W'(overflow_o),  W'(0));
        check("rst_unf",   W'(underflow_o), W'(0));
        check("rst_data",  restore_data_o, '0);

        // Single push/pop with cycle-exact timing
        push_i       = 1'b1;
        store_data_i = pat(8'h11);
        tick();
        push_i = 1'b0;
        check("push_n1_busy",  W'(busy_o),  W'(1));
        check("push_n1_depth", W'(depth_o), W'(0));
        tick();
        check("push_n2_depth", W'(depth_o), W'(1));
        check("push_n2_busy",  W'(busy_o),  W'(0));
        pop_i = 1'b1;
        tick();
        check("pop_n1_depth", W'(depth_o), W'(0));
        check("pop_n1_valid", W'(restore_valid_o), W'(0));
        tick();
        check("pop_n2_valid", W'(restore_valid_o), W'(1));
        check("pop_n2_data",  restore_data_o, pat(8'h11));
        pop_i = 1'b0;
        tick();
        check("pop_n3_valid", W'(restore_valid_o), W'(0));
        check("pop_n3_empty", W'(empty_o), W'(1));
        check("pop_hold_data", restore_data_o, pat(8'h11));

        // LIFO order
        do_push(pat(8'hA1));
        do_push(pat(8'hB2));
        do_push(pat(8'hC3));
        check("lifo_depth3", W'(depth_o), W'(3));
        do_pop(rd);
        check("lifo_pop1", rd, pat(8'hC3));
        check("lifo_depth2", W'(depth_o), W'(2));
        do_pop(rd);
        check("lifo_pop2", rd, pat(8'hB2));
        check("lifo_depth1", W'(depth_o), W'(1));
        do_pop(rd);
        check("lifo_pop3", rd, pat(8'hA1));
        check("lifo_depth0", W'(depth_o), W'(0));

        // Overflow
        do_push(pat(8'h01));
        do_push(pat(8'h02));
        do_push(pat(8'h03));
        do_push(pat(8'h04));
        check("ovf_full",  W'(full_o),  W'(1));
        check("ovf_depth4", W'(depth_o), W'(4));
        push_i       = 1'b1;
        store_data_i = pat(8'hEE);
        tick();
        push_i = 1'b0;
        check("ovf_flag",  W'(overflow_o), W'(1));
        check("ovf_busy",  W'(busy_o),     W'(0));
        check("ovf_depth_kept", W'(depth_o), W'(4));
        do_pop(rd);
        check("ovf_pop_top", rd, pat(8'h04));
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("ovf_clr", W'(overflow_o), W'(0));
        do_pop(rd);
        do_pop(rd);
        do_pop(rd);
        check("ovf_pop_bottom", rd, pat(8'h01));
        check("ovf_drained", W'(empty_o), W'(1));

        // Underflow
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        check("unf_flag",  W'(underflow_o), W'(1));
        check("unf_valid", W'(restore_valid_o), W'(0));
        check("unf_depth", W'(depth_o), W'(0));
        check("unf_busy",  W'(busy_o), W'(0));
        do_push(pat(8'h5A));
        check("unf_push_depth", W'(depth_o), W'(1));
        do_pop(rd);
        check("unf_push_data", rd, pat(8'h5A));
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("unf_clr", W'(underflow_o), W'(0));

        // Simultaneous push and pop: push goes first
        do_push(pat(8'hA5));
        push_i       = 1'b1;
        pop_i        = 1'b1;
        store_data_i = pat(8'hB6);
        tick();
        push_i = 1'b0;
        check("sim_write_busy", W'(busy_o), W'(1));
        tick();
        check("sim_depth2", W'(depth_o), W'(2));
        pop_i = 1'b0;
        do_pop(rd);
        check("sim_pop_data", rd, pat(8'hB6));
        check("sim_depth1", W'(depth_o), W'(1));
        do_pop(rd);
        check("sim_pop_rest", rd, pat(8'hA5));

        // Pending push during READ, second push while still busy overflows
        do_push(pat(8'h0A));
        do_push(pat(8'h0B));
        pop_i = 1'b1;
        tick();
        check("pend_read_depth", W'(depth_o), W'(1));
        push_i       = 1'b1;
        store_data_i = pat(8'hD0);
        tick();
        check("pend_resp_valid", W'(restore_valid_o), W'(1));
        check("pend_resp_data",  restore_data_o, pat(8'h0B));
        pop_i        = 1'b0;
        store_data_i = pat(8'hF0);
        tick();
        push_i = 1'b0;
        check("pend_ovf", W'(overflow_o), W'(1));
        check("pend_idle_depth", W'(depth_o), W'(1));
        tick();
        check("pend_write_busy", W'(busy_o), W'(1));
        tick();
        check("pend_depth_end", W'(depth_o), W'(2));
        do_pop(rd);
        check("pend_pop_data", rd, pat(8'hD0));

        // Reset during WRITE abandons the write
        push_i       = 1'b1;
        store_data_i = pat(8'h77);
        tick();
        push_i = 1'b0;
        check("rw_busy", W'(busy_o), W'(1));
        check("rw_ovf_before", W'(overflow_o), W'(1));
        rst_ni = 1'b0;
        tick();
        check("rw_depth", W'(depth_o), W'(0));
        check("rw_busy0", W'(busy_o), W'(0));
        check("rw_ovf",   W'(overflow_o), W'(0));
        check("rw_unf",   W'(underflow_o), W'(0));
        check("rw_data",  restore_data_o, '0);
        check("rw_empty", W'(empty_o), W'(1));
        rst_ni = 1'b1;
        tick();
        check("rw_depth_after", W'(depth_o), W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
